// File: rtl/spike_seq_pkg.sv
// Shared types and default widths for the STDP spike-pair stimulus sequencer.
//   state_e   : sequencer FSM states
//   cfg_t     : one train configuration at the default widths
//   CNT_W_DEF / NPAIR_W_DEF : default counter and pair-index widths
package spike_seq_pkg;

   localparam int CNT_W_DEF   = 32;
   localparam int NPAIR_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic signed [CNT_W_DEF-1:0] delay;
      logic        [CNT_W_DEF-1:0] width;
      logic        [CNT_W_DEF-1:0] period;
      logic        [NPAIR_W_DEF-1:0] pairs;
   } cfg_t;

endpackage

// File: rtl/pulse_window.sv
// Pulse window decode: level is high while off <= phase < off + width.
// The upper bound is formed one bit wider than the operands, so off + width
// cannot overflow.
//   phase : current phase within the pair period
//   off   : pulse onset, in cycles from phase 0
//   width : pulse high time, in cycles (0 gives no pulse)
//   level : window membership of phase
module pulse_window
   import spike_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic [CNT_W-1:0] phase,
   input  logic [CNT_W-1:0] off,
   input  logic [CNT_W-1:0] width,
   output logic             level
);

   logic [CNT_W:0] win_end;

   assign win_end = {1'b0, off} + {1'b0, width};
   assign level   = (phase >= off) && ({1'b0, phase} < win_end);

endmodule

// File: rtl/spike_pair_seq.sv
// Spike-pair train sequencer driving the tp1 (pre) / td4 (post) inputs and
// the enable of top64. It plays cfg_pairs pre/post pairs with a signed
// pre-to-post offset, a pulse width and a pair period, all in clk_0_1ps cycles.
//   clk_0_1ps, reset        : clock, synchronous active-high reset
//   start, abort            : begin a train (IDLE only) / stop it (RUN only)
//   cfg_delay/width/period/pairs : train configuration, latched on start
//   tp1, td4, enable_out    : stimulus levels to top64
//   busy, done, cfg_err     : status (RUN level, end pulse, rejected start pulse)
//   pair_idx                : index of the current pair, from 0
//
// state | meaning
// IDLE  | waiting for start; start validates and latches the configuration
// RUN   | phase counts 0..period-1 per pair; tp1/td4 decoded from phase
// DONE  | one-cycle done pulse, then back to IDLE
module spike_pair_seq
   import spike_seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int NPAIR_W = NPAIR_W_DEF
) (
   input  logic                    clk_0_1ps,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic signed [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0]        cfg_width,
   input  logic [CNT_W-1:0]        cfg_period,
   input  logic [NPAIR_W-1:0]      cfg_pairs,
   output logic                    tp1,
   output logic                    td4,
   output logic                    enable_out,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err,
   output logic [NPAIR_W-1:0]      pair_idx
);

   state_e state_q, state_d;

   logic [CNT_W-1:0]   phase_q, phase_d;
   logic [CNT_W-1:0]   width_q, width_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   pre_off_q, pre_off_d;
   logic [CNT_W-1:0]   post_off_q, post_off_d;
   logic [NPAIR_W-1:0] pairs_left_q, pairs_left_d;
   logic [NPAIR_W-1:0] pair_idx_q, pair_idx_d;
   logic               tp1_q, tp1_d;
   logic               td4_q, td4_d;
   logic               cfg_err_q, cfg_err_d;

   logic [CNT_W-1:0]   delay_mag;
   logic [CNT_W:0]     span;
   logic               cfg_ok;
   logic               period_end;
   logic               pre_win;
   logic               post_win;

   // Magnitude of the signed delay; the most negative value still fits
   // because the result is unsigned.
   always_comb begin
      delay_mag = '0;
      if (cfg_delay[CNT_W-1]) begin
         delay_mag = CNT_W'(-cfg_delay);
      end else begin
         delay_mag = CNT_W'(cfg_delay);
      end
      span   = {1'b0, delay_mag} + {1'b0, cfg_width};
      cfg_ok = (cfg_period != '0) && (span <= {1'b0, cfg_period});
   end

   assign period_end = (phase_q == (period_q - CNT_W'(1)));

   // pairs_left is a down-counter; the train ends at its terminal count of 1.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      width_d      = width_q;
      period_d     = period_q;
      pre_off_d    = pre_off_q;
      post_off_d   = post_off_q;
      pairs_left_d = pairs_left_q;
      pair_idx_d   = pair_idx_q;
      cfg_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (start) begin
               if (cfg_ok) begin
                  width_d      = cfg_width;
                  period_d     = cfg_period;
                  pre_off_d    = cfg_delay[CNT_W-1] ? delay_mag : '0;
                  post_off_d   = cfg_delay[CNT_W-1] ? '0 : delay_mag;
                  pairs_left_d = cfg_pairs;
                  pair_idx_d   = '0;
                  state_d      = (cfg_pairs == '0) ? DONE : RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = DONE;
               phase_d = '0;
            end else if (period_end) begin
               phase_d      = '0;
               pair_idx_d   = pair_idx_q + NPAIR_W'(1);
               pairs_left_d = pairs_left_q - NPAIR_W'(1);
               if (pairs_left_q == NPAIR_W'(1)) begin
                  state_d = DONE;
               end
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Windows are decoded on the next-cycle phase/offsets so that the
   // registered tp1/td4 line up with the registered phase.
   pulse_window #(.CNT_W(CNT_W)) u_pre_win (
      .phase (phase_d),
      .off   (pre_off_d),
      .width (width_d),
      .level (pre_win)
   );

   pulse_window #(.CNT_W(CNT_W)) u_post_win (
      .phase (phase_d),
      .off   (post_off_d),
      .width (width_d),
      .level (post_win)
   );

   assign tp1_d = (state_d == RUN) && pre_win;
   assign td4_d = (state_d == RUN) && post_win;

   always_ff @(posedge clk_0_1ps) begin
      if (reset) begin
         state_q      <= IDLE;
         phase_q      <= '0;
         width_q      <= '0;
         period_q     <= '0;
         pre_off_q    <= '0;
         post_off_q   <= '0;
         pairs_left_q <= '0;
         pair_idx_q   <= '0;
         tp1_q        <= 1'b0;
         td4_q        <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         width_q      <= width_d;
         period_q     <= period_d;
         pre_off_q    <= pre_off_d;
         post_off_q   <= post_off_d;
         pairs_left_q <= pairs_left_d;
         pair_idx_q   <= pair_idx_d;
         tp1_q        <= tp1_d;
         td4_q        <= td4_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign tp1        = tp1_q;
   assign td4        = td4_q;
   assign busy       = (state_q == RUN);
   assign enable_out = busy;
   assign done       = (state_q == DONE);
   assign cfg_err    = cfg_err_q;
   assign pair_idx   = pair_idx_q;

endmodule

// File: tb/tb_spike_pair_seq.sv
// Bench for spike_pair_seq: table of train configurations plus hand-written
// abort / reset / busy-start sequences, checked cycle by cycle against a
// queue of expected outputs produced by a behavioural model of the train.
module tb_spike_pair_seq;
   import spike_seq_pkg::*;

   localparam int CW = CNT_W_DEF;
   localparam int NW = NPAIR_W_DEF;

   logic                 clk_0_1ps = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 abort;
   logic signed [CW-1:0] cfg_delay;
   logic [CW-1:0]        cfg_width;
   logic [CW-1:0]        cfg_period;
   logic [NW-1:0]        cfg_pairs;
   logic                 tp1;
   logic                 td4;
   logic                 enable_out;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;
   logic [NW-1:0]        pair_idx;

   spike_pair_seq dut (
      .clk_0_1ps  (clk_0_1ps),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .cfg_delay  (cfg_delay),
      .cfg_width  (cfg_width),
      .cfg_period (cfg_period),
      .cfg_pairs  (cfg_pairs),
      .tp1        (tp1),
      .td4        (td4),
      .enable_out (enable_out),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .pair_idx   (pair_idx)
   );

   always #5 clk_0_1ps = ~clk_0_1ps;

   typedef struct packed {
      logic          tp1;
      logic          td4;
      logic          busy;
      logic          done;
      logic          cfg_err;
      logic          chk_idx;
      logic [NW-1:0] idx;
   } exp_t;

   typedef struct {
      cfg_t cfg;
      bit   bad_cfg;
   } vec_t;

   exp_t  exp_q[$];
   vec_t  vecs[10];
   int    total = 0;
   int    bad   = 0;
   string cur_name = "reset";

   function automatic cfg_t mk_cfg(int d, int unsigned w, int unsigned p, int unsigned n);
      cfg_t c;
      c.delay  = d;
      c.width  = w;
      c.period = p;
      c.pairs  = NW'(n);
      return c;
   endfunction

   function automatic vec_t mk(int d, int unsigned w, int unsigned p, int unsigned n, bit b);
      vec_t v;
      v.cfg     = mk_cfg(d, w, p, n);
      v.bad_cfg = b;
      return v;
   endfunction

   // Expected outputs in the k-th RUN cycle (k from 0) of a train.
   function automatic exp_t model(cfg_t c, longint k);
      exp_t   e;
      longint per, ph, pr, d, w, pre, post;
      per = longint'(c.period);
      ph  = k % per;
      pr  = k / per;
      d   = longint'($signed(c.delay));
      w   = longint'(c.width);
      pre  = (d < 0) ? -d : 0;
      post = (d < 0) ? 0 : d;
      e = '0;
      e.busy    = 1'b1;
      e.tp1     = (ph >= pre) && (ph < pre + w);
      e.td4     = (ph >= post) && (ph < post + w);
      e.chk_idx = 1'b1;
      e.idx     = NW'(pr);
      return e;
   endfunction

   task automatic push_run(cfg_t c, longint n);
      for (longint k = 0; k < n; k++) exp_q.push_back(model(c, k));
   endtask

   task automatic push_flag(bit dn, bit er, bit ci, logic [NW-1:0] idx);
      exp_t e;
      e = '0;
      e.done    = dn;
      e.cfg_err = er;
      e.chk_idx = ci;
      e.idx     = idx;
      exp_q.push_back(e);
   endtask

   task automatic cmp_now();
      exp_t       e;
      logic [5:0] got, want;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty at t=%0t", cur_name, $time);
         return;
      end
      e    = exp_q.pop_front();
      got  = {tp1, td4, busy, done, cfg_err, enable_out};
      want = {e.tp1, e.td4, e.busy, e.done, e.cfg_err, e.busy};
      if (got !== want || (e.chk_idx && pair_idx !== e.idx)) begin
         bad++;
         $display("FAIL %s t=%0t: got tp1,td4,busy,done,err,en=%b idx=%0d, want %b idx=%0d (idx checked=%0b)",
                  cur_name, $time, got, pair_idx, want, e.idx, e.chk_idx);
      end
   endtask

   task automatic cmp_cycles(int n);
      repeat (n) begin
         @(posedge clk_0_1ps);
         #1;
         cmp_now();
      end
   endtask

   task automatic scramble_cfg();
      cfg_delay  = $urandom;
      cfg_width  = $urandom;
      cfg_period = $urandom;
      cfg_pairs  = NW'($urandom);
   endtask

   // start is seen by the edge E0; first RUN cycle is sampled right after E0.
   task automatic drive_start(cfg_t c, bit ab);
      @(negedge clk_0_1ps);
      start      = 1'b1;
      abort      = ab;
      cfg_delay  = c.delay;
      cfg_width  = c.width;
      cfg_period = c.period;
      cfg_pairs  = c.pairs;
      @(posedge clk_0_1ps);
      #1;
      start = 1'b0;
      abort = 1'b0;
      scramble_cfg();
   endtask

   task automatic run_vec(vec_t v, bit ab);
      longint n;
      if (v.bad_cfg) begin
         push_flag(1'b0, 1'b1, 1'b0, '0);
         push_flag(1'b0, 1'b0, 1'b0, '0);
         drive_start(v.cfg, ab);
         cmp_now();
         cmp_cycles(1);
      end else begin
         n = longint'(v.cfg.pairs) * longint'(v.cfg.period);
         push_run(v.cfg, n);
         push_flag(1'b1, 1'b0, 1'b0, '0);
         push_flag(1'b0, 1'b0, 1'b0, '0);
         drive_start(v.cfg, ab);
         cmp_now();
         cmp_cycles(int'(n) + 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      cfg_t nom, c;
      nom = mk_cfg(10, 100, 1000, 2);

      vecs[0] = mk(10, 100, 1000, 2, 1'b0);
      vecs[1] = mk(-20, 5, 50, 1, 1'b0);
      vecs[2] = mk(40, 20, 50, 1, 1'b1);
      vecs[3] = mk(5, 3, 10, 0, 1'b0);
      vecs[4] = mk(1, 0, 4, 3, 1'b0);
      vecs[5] = mk(3, 2, 5, 2, 1'b0);
      vecs[6] = mk(-4, 2, 5, 1, 1'b1);
      vecs[7] = mk(0, 0, 0, 1, 1'b1);
      vecs[8] = mk(0, 7, 7, 2, 1'b0);
      vecs[9] = mk(0, 1, 1, 3, 1'b0);

      // Reset overrides a simultaneous start and abort.
      reset      = 1'b1;
      start      = 1'b1;
      abort      = 1'b1;
      cfg_delay  = nom.delay;
      cfg_width  = nom.width;
      cfg_period = nom.period;
      cfg_pairs  = nom.pairs;
      push_flag(1'b0, 1'b0, 1'b1, '0);
      push_flag(1'b0, 1'b0, 1'b1, '0);
      push_flag(1'b0, 1'b0, 1'b1, '0);
      cmp_cycles(2);
      @(negedge clk_0_1ps);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      cmp_cycles(1);

      for (int i = 0; i < 10; i++) begin
         cur_name = $sformatf("vec%0d", i);
         run_vec(vecs[i], 1'b0);
      end

      // start and abort together in IDLE: the train still runs in full.
      cur_name = "start_abort_idle";
      run_vec(vecs[1], 1'b1);

      // Abort at phase 30 of pair 1, then a fresh start is accepted.
      cur_name = "abort";
      push_run(nom, 1031);
      push_flag(1'b1, 1'b0, 1'b0, '0);
      push_flag(1'b0, 1'b0, 1'b0, '0);
      drive_start(nom, 1'b0);
      cmp_now();
      cmp_cycles(1030);
      abort = 1'b1;
      @(posedge clk_0_1ps);
      #1;
      abort = 1'b0;
      cmp_now();
      cmp_cycles(1);
      cur_name = "after_abort";
      run_vec(vecs[5], 1'b0);

      // A second start with another config at phase 5 must be ignored.
      cur_name = "start_busy";
      c = mk_cfg(3, 4, 10, 2);
      push_run(c, 20);
      push_flag(1'b1, 1'b0, 1'b0, '0);
      push_flag(1'b0, 1'b0, 1'b0, '0);
      drive_start(c, 1'b0);
      cmp_now();
      cmp_cycles(5);
      start      = 1'b1;
      cfg_delay  = 0;
      cfg_width  = 9;
      cfg_period = 9;
      cfg_pairs  = 5;
      @(posedge clk_0_1ps);
      #1;
      start = 1'b0;
      cmp_now();
      cmp_cycles(15);

      // Reset mid-train: everything low next cycle and no done afterwards.
      cur_name = "reset_mid";
      c = mk_cfg(-2, 3, 8, 4);
      push_run(c, 15);
      repeat (4) push_flag(1'b0, 1'b0, 1'b1, '0);
      drive_start(c, 1'b0);
      cmp_now();
      cmp_cycles(14);
      reset = 1'b1;
      @(posedge clk_0_1ps);
      #1;
      reset = 1'b0;
      cmp_now();
      cmp_cycles(3);

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
